// File: rtl/eval_run_ctrl.sv
// rtl/eval_run_ctrl.sv - evaluator run sequencer with output word FIFO
// Resets the evaluator, runs it under a cycle budget, and queues its output words for a sink.
module eval_run_ctrl #(
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] cycle_limit,
  output logic        eval_rst_n,
  input  logic        eval_valid,
  input  logic [31:0] eval_data,
  input  logic        eval_halt,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
  output logic [31:0] cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   RST_LAST = 32'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_rst_cnt;
  logic [31:0] r_limit;
  logic [31:0] r_cycle_count;
  logic        r_timeout;
  logic        r_overflow;

  logic [31:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic        w_start_acc;
  logic        w_set_timeout;
  logic        w_run;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [31:0] w_cc_inc;

  assign w_run    = (r_state == S_RUN);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_pop    = !w_empty && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign w_push   = w_run && eval_valid && (!w_full || w_pop);
  assign w_drop   = w_run && eval_valid && w_full && !w_pop;
  assign w_cc_inc = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count : r_cycle_count + 32'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_start_acc   = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_RST;
        end
      end
      S_RST: begin
        if (r_rst_cnt == RST_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Halt beats the budget when both land on the same cycle.
        if (eval_halt) begin
          w_state_nxt = S_DRAIN;
        end else if (r_limit != 32'd0 && w_cc_inc == r_limit) begin
          w_set_timeout = 1'b1;
          w_state_nxt   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_rst_cnt <= 32'd0;
    end else if (r_state == S_RST) begin
      r_rst_cnt <= r_rst_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_limit       <= 32'd0;
      r_cycle_count <= 32'd0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (w_start_acc) begin
      r_limit       <= cycle_limit;
      r_cycle_count <= 32'd0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_run) r_cycle_count <= w_cc_inc;
      if (w_set_timeout) r_timeout <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= eval_data;
  end

  assign eval_rst_n  = w_run;
  assign out_valid   = !w_empty;
  assign out_data    = r_mem[r_rptr];
  assign busy        = (r_state == S_RST) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_eval_run_ctrl.sv
// tb/tb_eval_run_ctrl.sv - scoreboard bench for eval_run_ctrl
// Directed scenarios followed by randomized runs against a queue-based run model.
module tb_eval_run_ctrl;

  localparam int DEPTH      = 16;
  localparam int RST_CYCLES = 2;
  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] cycle_limit;
  logic        eval_rst_n;
  logic        eval_valid;
  logic [31:0] eval_data;
  logic        eval_halt;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [31:0] cycle_count;

  eval_run_ctrl #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .cycle_limit(cycle_limit),
    .eval_rst_n(eval_rst_n), .eval_valid(eval_valid), .eval_data(eval_data),
    .eval_halt(eval_halt), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .timeout(timeout),
    .overflow(overflow), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference run model
  int          m_phase = P_IDLE;
  int          m_rst_left = 0;
  int          m_cnt = 0;
  logic [31:0] m_cc = 0;
  logic [31:0] m_lim = 0;
  bit          m_to = 0;
  bit          m_ovf = 0;
  logic [31:0] q_exp[$];
  int          n_popped = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit pop;
    bit push;
    @(posedge clk);
    pop  = (m_cnt > 0) && out_ready;
    push = 1'b0;
    if (reset) begin
      m_phase = P_IDLE; m_cnt = 0; m_cc = 0; m_to = 0; m_ovf = 0;
      q_exp.delete();
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start) begin
            m_phase = P_RST; m_rst_left = RST_CYCLES; m_lim = cycle_limit;
            m_cc = 0; m_to = 0; m_ovf = 0; m_cnt = 0; pop = 0;
            q_exp.delete();
          end
        end
        P_RST: begin
          m_rst_left--;
          if (m_rst_left == 0) m_phase = P_RUN;
        end
        P_RUN: begin
          if (m_cc != 32'hFFFF_FFFF) m_cc++;
          if (eval_valid) begin
            if (m_cnt < DEPTH || pop) push = 1'b1;
            else m_ovf = 1;
          end
          if (eval_halt) m_phase = P_DRAIN;
          else if (m_lim != 0 && m_cc == m_lim) begin
            m_to = 1; m_phase = P_DRAIN;
          end
        end
        default: begin
          if (m_cnt == 0) m_phase = P_DONE;
        end
      endcase
      if (push) begin
        q_exp.push_back(eval_data);
        m_cnt++;
      end
      if (pop) m_cnt--;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL out_data: got %0h expected no word at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, q_exp.pop_front());
          n_popped++;
        end
      end
      check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
      check("eval_rst_n", 32'(eval_rst_n), 32'(m_phase == P_RUN));
      check("busy", 32'(busy), 32'(m_phase == P_RST || m_phase == P_RUN || m_phase == P_DRAIN));
      check("done", 32'(done), 32'(m_phase == P_DONE));
      check("timeout", 32'(timeout), 32'(m_to));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("cycle_count", cycle_count, m_cc);
    end
  end

  task automatic idle_in();
    start = 0; eval_valid = 0; eval_halt = 0;
  endtask

  task automatic do_start(input logic [31:0] lim);
    cycle_limit = lim;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int k;
    k = 0;
    while (m_phase != ph && k < budget) begin
      step();
      k++;
    end
    n_chk++;
    if (m_phase != ph) begin
      n_err++;
      $display("FAIL %s: phase %0d after %0d cycles, required %0d", name, m_phase, k, ph);
    end
  endtask

  initial begin
    int p0;
    int k;
    reset = 1; out_ready = 0; cycle_limit = 0; eval_data = 0;
    idle_in();
    step();
    mon_en = 1;
    reset = 0;
    step();
    check("reset_busy", 32'(busy), 0);
    check("reset_cycle_count", cycle_count, 0);

    // Normal run: 'H','i' at RUN cycles 3,4, halt at 6
    out_ready = 1; p0 = n_popped;
    do_start(0);
    wait_phase(P_RUN, 10, "normal_run");
    for (int c = 1; c <= 6; c++) begin
      eval_valid = (c == 3 || c == 4);
      eval_data  = (c == 3) ? 32'h48 : 32'h69;
      eval_halt  = (c == 6);
      step();
    end
    idle_in();
    wait_phase(P_DONE, 40, "normal_done");
    check("normal_cycle_count", cycle_count, 6);
    check("normal_done", 32'(done), 1);
    check("normal_timeout", 32'(timeout), 0);
    check("normal_words", n_popped - p0, 2);

    // Timeout at limit 10
    do_start(10);
    wait_phase(P_RUN, 10, "timeout_run");
    wait_phase(P_DONE, 40, "timeout_done");
    check("timeout_flag", 32'(timeout), 1);
    check("timeout_cycle_count", cycle_count, 10);

    // Overflow: 20 words into 16 entries
    out_ready = 0;
    do_start(0);
    wait_phase(P_RUN, 10, "ovf_run");
    for (int i = 0; i < 20; i++) begin
      eval_valid = 1; eval_data = 32'h100 + 32'(i);
      step();
    end
    eval_valid = 0; eval_halt = 1;
    step();
    eval_halt = 0;
    check("ovf_flag", 32'(overflow), 1);
    p0 = n_popped; out_ready = 1;
    wait_phase(P_DONE, 60, "ovf_done");
    check("ovf_drained", n_popped - p0, 16);

    // Full FIFO with a same-cycle pop accepts the word
    out_ready = 0;
    do_start(0);
    wait_phase(P_RUN, 10, "full_run");
    for (int i = 0; i < 16; i++) begin
      eval_valid = 1; eval_data = 32'h200 + 32'(i);
      step();
    end
    eval_data = 32'h2FF; out_ready = 1;
    step();
    eval_valid = 0; out_ready = 0;
    check("full_pop_overflow", 32'(overflow), 0);
    check("full_pop_occupancy", 32'(dut.r_count), 16);
    eval_halt = 1;
    step();
    eval_halt = 0; out_ready = 1;
    wait_phase(P_DONE, 60, "full_done");

    // Halt and limit on the same cycle
    do_start(5);
    wait_phase(P_RUN, 10, "tie_run");
    for (int c = 1; c <= 5; c++) begin
      eval_halt = (c == 5);
      step();
    end
    eval_halt = 0;
    check("tie_timeout", 32'(timeout), 0);
    check("tie_cycle_count", cycle_count, 5);
    wait_phase(P_DONE, 40, "tie_done");

    // Reset mid-RUN with 3 words queued
    out_ready = 0;
    do_start(0);
    wait_phase(P_RUN, 10, "rst_run");
    for (int i = 0; i < 3; i++) begin
      eval_valid = 1; eval_data = 32'h300 + 32'(i);
      step();
    end
    eval_valid = 0; reset = 1;
    step();
    reset = 0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_eval_rst_n", 32'(eval_rst_n), 0);
    check("rst_cycle_count", cycle_count, 0);
    out_ready = 1; p0 = n_popped;
    do_start(0);
    wait_phase(P_RUN, 10, "rst2_run");
    eval_valid = 1; eval_data = 32'h400; step();
    eval_data = 32'h401; eval_halt = 1; step();
    idle_in();
    wait_phase(P_DONE, 40, "rst2_done");
    check("rst2_words", n_popped - p0, 2);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      out_ready = 1'($urandom_range(0, 1));
      do_start(($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40)));
      k = 0;
      while (!(m_phase == P_DONE || m_phase == P_IDLE) && k < 400) begin
        eval_valid = 1'($urandom_range(0, 1));
        eval_data  = $urandom;
        eval_halt  = ($urandom_range(0, 24) == 0);
        out_ready  = ($urandom_range(0, 3) != 0);
        start      = ($urandom_range(0, 9) == 0);
        reset      = ($urandom_range(0, 299) == 0);
        step();
        k++;
      end
      reset = 0;
      idle_in();
      n_chk++;
      if (k >= 400) begin
        n_err++;
        $display("FAIL random_run_%0d: still in phase %0d after %0d cycles", r, m_phase, k);
      end
    end

    out_ready = 1;
    repeat (20) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
